// File: rtl/ysyx_040750_trap_seq_if.sv
// Write-back side bundle for the trap/mret sequencer: request inputs, CSR snapshot,
// the single CSR write port, and the fetch redirect.
interface ysyx_040750_trap_seq_if;
   logic        I_trap_req;
   logic [63:0] I_trap_cause;
   logic [63:0] I_trap_pc;
   logic        I_mret_req;
   logic        I_csr_wen_WB;
   logic [11:0] I_csr_addr_WB;
   logic [63:0] I_csr_data_WB;
   logic [63:0] I_mtvec;
   logic [63:0] I_mepc;
   logic [63:0] I_mstatus;
   logic        O_csr_wen;
   logic [11:0] O_csr_addr;
   logic [63:0] O_csr_wdata;
   logic        O_trap_ack;
   logic        O_flush;
   logic        O_busy;
   logic        O_redirect_valid;
   logic [63:0] O_redirect_pc;
   logic [2:0]  O_dbg_state;

   modport master (
      output I_trap_req, I_trap_cause, I_trap_pc, I_mret_req,
             I_csr_wen_WB, I_csr_addr_WB, I_csr_data_WB,
             I_mtvec, I_mepc, I_mstatus,
      input  O_csr_wen, O_csr_addr, O_csr_wdata, O_trap_ack, O_flush,
             O_busy, O_redirect_valid, O_redirect_pc, O_dbg_state
   );

   modport slave (
      input  I_trap_req, I_trap_cause, I_trap_pc, I_mret_req,
             I_csr_wen_WB, I_csr_addr_WB, I_csr_data_WB,
             I_mtvec, I_mepc, I_mstatus,
      output O_csr_wen, O_csr_addr, O_csr_wdata, O_trap_ack, O_flush,
             O_busy, O_redirect_valid, O_redirect_pc, O_dbg_state
   );
endinterface

// File: rtl/ysyx_040750_trap_seq.sv
// Trap/mret sequencer owning the machine-mode CSR write port: one CSR write per cycle,
// then a fetch redirect; ordinary WB CSR writes pass through while idle.
module ysyx_040750_trap_seq (
   input logic                      I_sys_clk,
   input logic                      I_rst_n,
   ysyx_040750_trap_seq_if.slave    bus
);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_W_EPC    = 3'd1,
      S_W_CAUSE  = 3'd2,
      S_W_STATUS = 3'd3,
      S_T_REDIR  = 3'd4,
      S_R_STATUS = 3'd5,
      S_R_REDIR  = 3'd6
   } state_t;

   localparam logic [11:0] CSR_MSTATUS = 12'h300;
   localparam logic [11:0] CSR_MEPC    = 12'h341;
   localparam logic [11:0] CSR_MCAUSE  = 12'h342;

   state_t      r_state;
   logic [63:0] r_pc_q;
   logic [63:0] r_cause_q;
   logic [63:0] r_vec_q;
   logic [63:0] r_st_q;

   state_t      w_next;
   logic        w_accept;
   logic        w_wen;
   logic [11:0] w_addr;
   logic [63:0] w_wdata;
   logic        w_ack;
   logic        w_flush;
   logic        w_busy;
   logic        w_redir_v;
   logic [63:0] w_redir_pc;
   logic [63:0] w_st_trap;
   logic [63:0] w_st_mret;

   // Request handshake: a trap/mret request is taken only in IDLE, in the same cycle it is
   // seen (O_trap_ack is the acknowledge, no ready/backpressure). Requests seen while busy
   // or while reset is held are dropped, never queued.
   assign w_accept = I_rst_n & (r_state == S_IDLE) & (bus.I_trap_req | bus.I_mret_req);

   // Trap entry: MPIE<-MIE, MIE<-0, MPP<-M.  Mret: MIE<-MPIE, MPIE<-1, MPP stays M.
   assign w_st_trap = {r_st_q[63:13], 2'b11, r_st_q[10:8], r_st_q[3], r_st_q[6:4], 1'b0, r_st_q[2:0]};
   assign w_st_mret = {r_st_q[63:13], 2'b11, r_st_q[10:8], 1'b1, r_st_q[6:4], r_st_q[7], r_st_q[2:0]};

   always_ff @(posedge I_sys_clk or negedge I_rst_n) begin
      if (!I_rst_n) begin
         r_state   <= S_IDLE;
         r_pc_q    <= '0;
         r_cause_q <= '0;
         r_vec_q   <= '0;
         r_st_q    <= '0;
      end else begin
         r_state <= w_next;
         if (w_accept) begin
            r_st_q <= bus.I_mstatus;
            if (bus.I_trap_req) begin
               r_pc_q    <= bus.I_trap_pc;
               r_cause_q <= bus.I_trap_cause;
               r_vec_q   <= bus.I_mtvec;
            end else begin
               r_vec_q   <= bus.I_mepc;
            end
         end
      end
   end

   always_comb begin
      w_next     = r_state;
      w_wen      = 1'b0;
      w_addr     = '0;
      w_wdata    = '0;
      w_ack      = 1'b0;
      w_flush    = 1'b0;
      w_busy     = 1'b1;
      w_redir_v  = 1'b0;
      w_redir_pc = '0;
      case (r_state)
         S_IDLE: begin
            w_busy = 1'b0;
            if (w_accept) begin
               w_ack   = 1'b1;
               w_flush = 1'b1;
               w_next  = bus.I_trap_req ? S_W_EPC : S_R_STATUS;
            end else begin
               w_wen   = bus.I_csr_wen_WB;
               w_addr  = bus.I_csr_addr_WB;
               w_wdata = bus.I_csr_data_WB;
            end
         end
         S_W_EPC: begin
            w_wen   = 1'b1;
            w_addr  = CSR_MEPC;
            w_wdata = r_pc_q;
            w_next  = S_W_CAUSE;
         end
         S_W_CAUSE: begin
            w_wen   = 1'b1;
            w_addr  = CSR_MCAUSE;
            w_wdata = r_cause_q;
            w_next  = S_W_STATUS;
         end
         S_W_STATUS: begin
            w_wen   = 1'b1;
            w_addr  = CSR_MSTATUS;
            w_wdata = w_st_trap;
            w_next  = S_T_REDIR;
         end
         // Direct mode only: the MODE field of mtvec is masked off.
         S_T_REDIR: begin
            w_redir_v  = 1'b1;
            w_redir_pc = {r_vec_q[63:2], 2'b00};
            w_next     = S_IDLE;
         end
         S_R_STATUS: begin
            w_wen   = 1'b1;
            w_addr  = CSR_MSTATUS;
            w_wdata = w_st_mret;
            w_next  = S_R_REDIR;
         end
         S_R_REDIR: begin
            w_redir_v  = 1'b1;
            w_redir_pc = r_vec_q;
            w_next     = S_IDLE;
         end
         default: begin
            w_busy = 1'b0;
            w_next = S_IDLE;
         end
      endcase
   end

   assign bus.O_csr_wen        = w_wen;
   assign bus.O_csr_addr       = w_addr;
   assign bus.O_csr_wdata      = w_wdata;
   assign bus.O_trap_ack       = w_ack;
   assign bus.O_flush          = w_flush;
   assign bus.O_busy           = w_busy;
   assign bus.O_redirect_valid = w_redir_v;
   assign bus.O_redirect_pc    = w_redir_pc;
   assign bus.O_dbg_state      = r_state;

endmodule

// File: tb/tb_ysyx_040750_trap_seq.sv
// Bench for ysyx_040750_trap_seq: directed scenarios plus random traffic, checked against
// a per-cycle queue of expected outputs built from the trap/mret sequence rules.
module tb_ysyx_040750_trap_seq;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   ysyx_040750_trap_seq_if bus ();

   ysyx_040750_trap_seq dut (
      .I_sys_clk (clk),
      .I_rst_n   (rst_n),
      .bus       (bus)
   );

   typedef struct {
      logic        wen;
      logic [11:0] addr;
      logic [63:0] wdata;
      logic        ack;
      logic        flush;
      logic        busy;
      logic        rv;
      logic [63:0] rpc;
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_err = 0;
   int   cyc_n = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s @cycle %0d: got 0x%0h expected 0x%0h", tag, cyc_n, got, exp);
      end
   endtask

   function automatic logic [63:0] st_after_trap(input logic [63:0] s);
      return (s & ~64'h1888) | 64'h1800 | (s[3] ? 64'h80 : 64'h0);
   endfunction

   function automatic logic [63:0] st_after_mret(input logic [63:0] s);
      return (s & ~64'h1888) | 64'h1880 | (s[7] ? 64'h8 : 64'h0);
   endfunction

   function automatic exp_t rec(input logic wen, input logic [11:0] addr, input logic [63:0] wdata,
                                input logic rv, input logic [63:0] rpc);
      exp_t e;
      e.wen = wen; e.addr = addr; e.wdata = wdata;
      e.ack = 1'b0; e.flush = 1'b0; e.busy = 1'b1;
      e.rv = rv; e.rpc = rpc;
      return e;
   endfunction

   // Model one cycle: outputs are judged #1 after the inputs change (mid-cycle, clear of posedge).
   task automatic step();
      exp_t e;
      e = '{wen: 1'b0, addr: 12'h0, wdata: 64'h0, ack: 1'b0, flush: 1'b0, busy: 1'b0, rv: 1'b0, rpc: 64'h0};
      #1;
      if (!rst_n) exp_q.delete();
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
      end else if (rst_n && bus.I_trap_req) begin
         e.ack = 1'b1; e.flush = 1'b1;
         exp_q.push_back(rec(1'b1, 12'h341, bus.I_trap_pc, 1'b0, 64'h0));
         exp_q.push_back(rec(1'b1, 12'h342, bus.I_trap_cause, 1'b0, 64'h0));
         exp_q.push_back(rec(1'b1, 12'h300, st_after_trap(bus.I_mstatus), 1'b0, 64'h0));
         exp_q.push_back(rec(1'b0, 12'h0, 64'h0, 1'b1, bus.I_mtvec & ~64'h3));
      end else if (rst_n && bus.I_mret_req) begin
         e.ack = 1'b1; e.flush = 1'b1;
         exp_q.push_back(rec(1'b1, 12'h300, st_after_mret(bus.I_mstatus), 1'b0, 64'h0));
         exp_q.push_back(rec(1'b0, 12'h0, 64'h0, 1'b1, bus.I_mepc));
      end else begin
         e.wen = bus.I_csr_wen_WB; e.addr = bus.I_csr_addr_WB; e.wdata = bus.I_csr_data_WB;
      end
      check("csr_wen",   bus.O_csr_wen,        e.wen);
      check("csr_addr",  bus.O_csr_addr,       e.addr);
      check("csr_wdata", bus.O_csr_wdata,      e.wdata);
      check("trap_ack",  bus.O_trap_ack,       e.ack);
      check("flush",     bus.O_flush,          e.flush);
      check("busy",      bus.O_busy,           e.busy);
      check("redir_v",   bus.O_redirect_valid, e.rv);
      check("redir_pc",  bus.O_redirect_pc,    e.rpc);
   endtask

   task automatic drive(input logic rst, input logic trap, input logic mret,
                        input logic [63:0] tpc, input logic [63:0] tcause,
                        input logic [63:0] mtvec, input logic [63:0] mepc, input logic [63:0] mst,
                        input logic wen, input logic [11:0] addr, input logic [63:0] data);
      @(negedge clk);
      cyc_n++;
      rst_n              = rst;
      bus.I_trap_req     = trap;
      bus.I_mret_req     = mret;
      bus.I_trap_pc      = tpc;
      bus.I_trap_cause   = tcause;
      bus.I_mtvec        = mtvec;
      bus.I_mepc         = mepc;
      bus.I_mstatus      = mst;
      bus.I_csr_wen_WB   = wen;
      bus.I_csr_addr_WB  = addr;
      bus.I_csr_data_WB  = data;
      step();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++)
         drive(1'b1, 1'b0, 1'b0, 64'h0, 64'h0, 64'h0, 64'h0, 64'h0, 1'b0, 12'h0, 64'h0);
   endtask

   initial begin
      // Reset state, including pass-through following its inputs while reset is held.
      drive(1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 64'h0, 64'h0, 64'h0, 1'b0, 12'h0, 64'h0);
      drive(1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 64'h0, 64'h0, 64'h0, 1'b1, 12'h305, 64'h1234);
      idle(2);

      // Trap with snapshot inputs changed after accept.
      drive(1'b1, 1'b1, 1'b0, 64'h8000_0010, 64'd11, 64'h8000_0101, 64'h0, 64'h8, 1'b0, 12'h0, 64'h0);
      check("tp_ack", bus.O_trap_ack, 64'h1);
      drive(1'b1, 1'b0, 1'b0, 64'h0, 64'h0, 64'hdead_beef, 64'h0, 64'hffff, 1'b0, 12'h0, 64'h0);
      check("tp_epc", bus.O_csr_wdata, 64'h8000_0010);
      drive(1'b1, 1'b0, 1'b0, 64'h0, 64'h0, 64'hdead_beef, 64'h0, 64'hffff, 1'b0, 12'h0, 64'h0);
      drive(1'b1, 1'b0, 1'b0, 64'h0, 64'h0, 64'hdead_beef, 64'h0, 64'hffff, 1'b0, 12'h0, 64'h0);
      check("tp_status", bus.O_csr_wdata, 64'h1880);
      drive(1'b1, 1'b0, 1'b0, 64'h0, 64'h0, 64'hdead_beef, 64'h0, 64'hffff, 1'b0, 12'h0, 64'h0);
      check("tp_redir", bus.O_redirect_pc, 64'h8000_0100);
      idle(1);

      // Mret; IDLE again at c3.
      drive(1'b1, 1'b0, 1'b1, 64'h0, 64'h0, 64'h0, 64'h8000_0014, 64'h1880, 1'b0, 12'h0, 64'h0);
      drive(1'b1, 1'b0, 1'b0, 64'h0, 64'h0, 64'h0, 64'h0, 64'h0, 1'b0, 12'h0, 64'h0);
      check("mr_status", bus.O_csr_wdata, 64'h1888);
      drive(1'b1, 1'b0, 1'b0, 64'h0, 64'h0, 64'h0, 64'h0, 64'h0, 1'b0, 12'h0, 64'h0);
      check("mr_redir", bus.O_redirect_pc, 64'h8000_0014);
      drive(1'b1, 1'b0, 1'b0, 64'h0, 64'h0, 64'h0, 64'h0, 64'h0, 1'b1, 12'h305, 64'h8000_0000);
      check("mr_idle_pass", bus.O_csr_wen, 64'h1);

      // Simultaneous trap+mret+WB write: trap wins, WB write dropped.
      drive(1'b1, 1'b1, 1'b1, 64'h8000_1000, 64'd2, 64'h8000_0200, 64'h9000_0000, 64'h88, 1'b1, 12'h305, 64'h55);
      idle(5);

      // Pass-through, then a WB write landing in W_CAUSE.
      drive(1'b1, 1'b0, 1'b0, 64'h0, 64'h0, 64'h0, 64'h0, 64'h0, 1'b1, 12'h305, 64'h8000_0000);
      drive(1'b1, 1'b1, 1'b0, 64'h8000_2000, 64'd7, 64'h8000_0300, 64'h0, 64'h0, 1'b0, 12'h0, 64'h0);
      idle(1);
      drive(1'b1, 1'b0, 1'b0, 64'h0, 64'h0, 64'h0, 64'h0, 64'h0, 1'b1, 12'h305, 64'habcd);
      check("wb_drop_addr", bus.O_csr_addr, 64'h342);
      idle(3);

      // Reset pulled in W_CAUSE.
      drive(1'b1, 1'b1, 1'b0, 64'h8000_3000, 64'd5, 64'h8000_0400, 64'h0, 64'h8, 1'b0, 12'h0, 64'h0);
      idle(1);
      drive(1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 64'h0, 64'h0, 64'h0, 1'b0, 12'h0, 64'h0);
      check("rst_busy", bus.O_busy, 64'h0);
      idle(4);

      // Back-to-back: second trap held from c1, accepted at c5.
      drive(1'b1, 1'b1, 1'b0, 64'h8000_4000, 64'd3, 64'h8000_0500, 64'h0, 64'h0, 1'b0, 12'h0, 64'h0);
      for (int i = 0; i < 5; i++)
         drive(1'b1, 1'b1, 1'b0, 64'h8000_5000, 64'd4, 64'h8000_0604, 64'h0, 64'h8, 1'b0, 12'h0, 64'h0);
      check("b2b_ack", bus.O_trap_ack, 64'h1);
      idle(5);

      // Random traffic with occasional reset pulses.
      for (int i = 0; i < 800; i++) begin
         logic r, t, m, w;
         r = ($urandom_range(0, 59) != 0);
         t = r && ($urandom_range(0, 5) == 0);
         m = r && ($urandom_range(0, 5) == 0);
         w = $urandom_range(0, 1);
         drive(r, t, m, {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
               {$urandom, $urandom}, {$urandom, $urandom}, w, 12'($urandom), {$urandom, $urandom});
      end
      idle(6);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/ysyx_040750_trap_seq.md
# ysyx_040750_trap_seq

Multi-cycle trap/mret sequencer that owns the single machine-mode CSR write port. It sits at the write-back stage, next to the CSR file and the CSR forwarding logic. On an exception or `ecall` it flushes the pipeline, writes `mepc`, `mcause` and `mstatus` one per cycle, then redirects fetch to `mtvec`. On `mret` it restores `mstatus` and redirects to `mepc`. When idle, it passes ordinary WB-stage CSR writes straight through to the CSR file.

## Interface
Parameters: none.

Ports:
- `I_sys_clk` in 1: clock; all state updates on the rising edge.
- `I_rst_n` in 1: asynchronous, active-low reset.
- `I_trap_req` in 1: WB-stage instruction raises an exception or `ecall`.
- `I_trap_cause` in 64: `mcause` value for the trap.
- `I_trap_pc` in 64: PC of the trapping instruction.
- `I_mret_req` in 1: WB-stage instruction is `mret`.
- `I_csr_wen_WB` in 1: ordinary CSR write request from WB.
- `I_csr_addr_WB` in 12: address for the WB write.
- `I_csr_data_WB` in 64: data for the WB write.
- `I_mtvec` in 64: current `mtvec` from the CSR file.
- `I_mepc` in 64: current `mepc` from the CSR file.
- `I_mstatus` in 64: current `mstatus` from the CSR file.
- `O_csr_wen` out 1: CSR write enable to the CSR file.
- `O_csr_addr` out 12: CSR write address.
- `O_csr_wdata` out 64: CSR write data.
- `O_trap_ack` out 1: a trap or mret was accepted this cycle.
- `O_flush` out 1: flush IF/ID/EX/MEM this cycle.
- `O_busy` out 1: sequencer active; front end stalls.
- `O_redirect_valid` out 1: load PC with `O_redirect_pc`.
- `O_redirect_pc` out 64: redirect target.

## Operation
States: `IDLE`, `W_EPC`, `W_CAUSE`, `W_STATUS`, `T_REDIR`, `R_STATUS`, `R_REDIR`.

IDLE
- Accept condition is `I_trap_req | I_mret_req`. On accept, drive `O_trap_ack=1` and `O_flush=1` combinationally.
- Trap has priority over mret when both are asserted.
- In the accept cycle, the WB write is dropped: `O_csr_wen=0`.
- Trap accept latches `pc_q←I_trap_pc`, `cause_q←I_trap_cause`, `vec_q←I_mtvec`, `st_q←I_mstatus`, then goes to `W_EPC`.
- Mret accept latches `vec_q←I_mepc`, `st_q←I_mstatus`, then goes to `R_STATUS`.
- With no accept, pass the WB write through combinationally: `O_csr_wen=I_csr_wen_WB`, with address and data passed likewise.

Trap sequence
- `W_EPC`: write 0x341 ← `pc_q`; next state `W_CAUSE`.
- `W_CAUSE`: write 0x342 ← `cause_q`; next state `W_STATUS`.
- `W_STATUS`: write 0x300 ← `st_q` with the following fields changed; next state `T_REDIR`.
  - bit7 (MPIE) ← `st_q[3]`
  - bit3 (MIE) ← 0
  - bits12:11 (MPP) ← 2'b11
  - all other bits unchanged
- `T_REDIR`: `O_redirect_valid=1`, `O_redirect_pc={vec_q[63:2],2'b00}` (direct mode; MODE bits ignored); next state `IDLE`.

Mret sequence
- `R_STATUS`: write 0x300 ← `st_q` with the following fields changed; next state `R_REDIR`.
  - bit3 ← `st_q[7]`
  - bit7 ← 1
  - bits12:11 ← 2'b11 (M-only core)
- `R_REDIR`: `O_redirect_valid=1`, `O_redirect_pc=vec_q`; next state `IDLE`.

Common rules
- `O_busy=1` in every state except `IDLE`.
- In non-IDLE states, `I_csr_wen_WB`, `I_trap_req` and `I_mret_req` are ignored. The pipeline is flushed, so any such request is spurious and is dropped, not queued.
- Outputs not listed for a state are 0.

## Timing
- Reset (async assert, sync release): state=`IDLE`; `pc_q`, `cause_q`, `vec_q`, `st_q` = 0. All outputs are 0 except the IDLE pass-through, which follows its inputs.
- Reset asserted mid-sequence aborts immediately; no further writes or redirects occur.
- Trap, accept at cycle 0: flush/ack at c0; `mepc` write c1; `mcause` write c2; `mstatus` write c3; redirect c4; back in IDLE c5, which can accept again. `O_busy` is high c1–c4.
- Mret, accept at c0: `mstatus` write c1; redirect c2; IDLE c3. `O_busy` is high c1–c2.
- Exactly one CSR write per cycle, never two.
- CSR file writes are taken at the clock edge ending the cycle in which `O_csr_wen=1`.
- Values of `I_mtvec`, `I_mepc` and `I_mstatus` are taken only at accept. Later changes do not affect the in-flight sequence.

## Test plan
- Trap: `I_trap_pc`=0x8000_0010, cause=11, mtvec=0x8000_0101, mstatus=0x8 → c1 (0x341, 0x8000_0010); c2 (0x342, 11); c3 (0x300, 0x1880); c4 redirect 0x8000_0100; `O_busy` high for 4 cycles.
- Mret: mepc=0x8000_0014, mstatus=0x1880 → c1 (0x300, 0x1888); c2 redirect 0x8000_0014; IDLE at c3.
- Simultaneous trap+mret+WB write in IDLE → trap sequence only; `O_csr_wen=0` at c0; no mret writes.
- Pass-through: IDLE, WB write (0x305, 0x8000_0000) → same cycle `O_csr_wen=1` with the same address/data. WB write during `W_CAUSE` → dropped; output is (0x342, cause).
- `I_rst_n` pulled low in `W_CAUSE` → all outputs 0 at once; after release, IDLE with no `mstatus` write and no redirect.
- Back-to-back: trap, then a new trap held from c1 → ignored until c5, accepted at c5, and the second sequence is complete and correct.
